// File: rtl/act_lut_pkg.sv
// Shared defaults and types for the activation-LUT arbiter slice.
// The arbiter and the interpolator pick their parameter defaults from here.
package act_lut_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int FW_DEF    = DW_DEF - AW_DEF;
  localparam int IDW_DEF   = $clog2(N_REQ_DEF);

  typedef logic [IDW_DEF-1:0]       req_id_t;
  typedef logic signed [DW_DEF-1:0] act_data_t;

  // Round-robin successor of requester index v among n requesters.
  function automatic int rr_succ(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/act_interp.sv
// Linear interpolation between two adjacent LUT entries:
// y = base + floor((next - base) * frac / 2^FW), wrapped to DW bits.
module act_interp
  import act_lut_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic [DW-1:0] i_base,
  input  logic [DW-1:0] i_next,
  input  logic [FW-1:0] i_frac,
  output logic [DW-1:0] o_y
);

  logic signed [DW:0]    w_diff;
  logic signed [DW+FW:0] w_prod;
  logic signed [DW+FW:0] w_shift;

  // Sign-extend both entries by one bit so next-base cannot overflow.
  assign w_diff  = {i_next[DW-1], i_next} - {i_base[DW-1], i_base};
  assign w_prod  = w_diff * $signed({1'b0, i_frac});
  assign w_shift = w_prod >>> FW;
  assign o_y     = i_base + w_shift[DW-1:0];

endmodule

// File: rtl/act_lut_arbiter.sv
// Round-robin arbiter in front of a shared activation LUT, followed by a
// two-stage (LUT read / result) pipeline with a ready/valid response port.
module act_lut_arbiter
  import act_lut_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  localparam int FW   = DW - AW,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [AW-1:0]         lut_addr,
  input  logic [DW-1:0]         lut_base,
  input  logic [DW-1:0]         lut_next,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_data,
  input  logic                  rsp_ready
);

  logic           r_a_valid;
  logic [DW-1:0]  r_a_x;
  logic [IDW-1:0] r_a_id;
  logic           r_o_valid;
  logic [IDW-1:0] r_o_id;
  logic [DW-1:0]  r_o_data;
  logic [IDW-1:0] r_ptr;

  logic           w_advance;
  logic           w_a_open;
  logic           w_gnt_found;
  logic [IDW-1:0] w_gnt_id;
  int             w_idx;
  logic           w_accept;
  logic [DW-1:0]  w_y;

  assign w_advance = ~r_o_valid | rsp_ready;
  assign w_a_open  = ~r_a_valid | w_advance;
  assign w_accept  = w_gnt_found & w_a_open & ~rst;

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_gnt_found && req_valid[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = IDW'(w_idx);
      end else begin
        w_gnt_found = w_gnt_found;
      end
    end
  end

  // One-hot ready for the granted requester, only when stage A can take it.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gnt_id] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Priority pointer moves past the winner only on an actual acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= IDW'(rr_succ(int'(w_gnt_id), N_REQ));
    end
  end

  // Stage A: holds the accepted x while the LUT is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_x     <= '0;
      r_a_id    <= '0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_x     <= req_data[w_gnt_id*DW +: DW];
      r_a_id    <= w_gnt_id;
    end else if (w_advance) begin
      r_a_valid <= 1'b0;
    end
  end

  assign lut_addr = r_a_x[DW-1:FW];

  act_interp #(
    .DW (DW),
    .FW (FW)
  ) u_interp (
    .i_base (lut_base),
    .i_next (lut_next),
    .i_frac (r_a_x[FW-1:0]),
    .o_y    (w_y)
  );

  // Output stage: frozen while the consumer stalls a valid response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_id    <= '0;
      r_o_data  <= '0;
    end else if (w_advance) begin
      r_o_valid <= r_a_valid;
      if (r_a_valid) begin
        r_o_id   <= r_a_id;
        r_o_data <= w_y;
      end
    end
  end

  assign rsp_valid = r_o_valid;
  assign rsp_id    = r_o_id;
  assign rsp_data  = r_o_data;

endmodule

// File: tb/tb_act_lut_arbiter.sv
// Self-checking bench for act_lut_arbiter: directed scenarios plus random
// traffic checked against a queue-based reference model and a LUT stub.
module tb_act_lut_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [AW-1:0]     lut_addr;
  logic [DW-1:0]     lut_base;
  logic [DW-1:0]     lut_next;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready;

  logic              ovr;
  int                n_vec  = 0;
  int                n_miss = 0;

  act_lut_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .lut_addr  (lut_addr),
    .lut_base  (lut_base),
    .lut_next  (lut_next),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  // LUT stub: entry a holds 16*a (a signed); addr 7 clamps, addr 15 wraps.
  function automatic int lut_val(input int a);
    return 16 * ((a >= 8) ? a - 16 : a);
  endfunction

  function automatic int stub_base(input int a, input logic o);
    return o ? 127 : lut_val(a);
  endfunction

  function automatic int stub_next(input int a, input logic o);
    if (o) return -128;
    if (a == 7) return lut_val(7);
    return lut_val((a + 1) % 16);
  endfunction

  always_comb begin
    lut_base = 8'(stub_base(int'(lut_addr), ovr));
    lut_next = 8'(stub_next(int'(lut_addr), ovr));
  end

  // Reference result: floor division done on plain integers.
  function automatic logic [7:0] ref_y(input logic [7:0] x, input logic o);
    int a, f, b, n, p, q;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    b = stub_base(a, o);
    n = stub_next(a, o);
    p = (n - b) * f;
    q = (p >= 0) ? p / 16 : (p - 15) / 16;
    return 8'(b + q);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding requests in acceptance order.
  int          q_id[$];
  logic [7:0]  q_y[$];
  int          last_id = N - 1;
  logic        hold_prev = 1'b0;
  logic [1:0]  hold_id;
  logic [7:0]  hold_data;

  always @(negedge clk) begin
    logic       can;
    logic [3:0] exp_rdy;
    int         g;
    if (rst) begin
      check("ready_in_rst", 32'(req_ready), 32'd0);
      q_id.delete();
      q_y.delete();
      last_id   = N - 1;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_id", 32'(rsp_id), 32'(hold_id));
        check("hold_data", 32'(rsp_data), 32'(hold_data));
      end
      can     = (q_id.size() < 2) || (rsp_valid && rsp_ready);
      exp_rdy = 4'd0;
      g       = -1;
      if (can) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_valid[(last_id + k) % N]) g = (last_id + k) % N;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (rsp_valid) begin
        if (q_id.size() == 0) begin
          check("stale_rsp", 32'd1, 32'd0);
        end else begin
          check("rsp_id", 32'(rsp_id), 32'(q_id[0]));
          check("rsp_data", 32'(rsp_data), 32'(q_y[0]));
          if (rsp_ready) begin
            void'(q_id.pop_front());
            void'(q_y.pop_front());
          end
        end
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_y.push_back(ref_y(req_data[g*8 +: 8], ovr));
        last_id = g;
      end
      hold_prev = rsp_valid && !rsp_ready;
      hold_id   = rsp_id;
      hold_data = rsp_data;
    end
  end

  // One isolated request on requester 0, checking LUT address and latency.
  task automatic single(input string tag, input logic [7:0] x, input logic [7:0] y);
    step();
    req_valid = 4'b0001;
    req_data  = {24'h0, x};
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check({tag, "_addr"}, 32'(lut_addr), 32'(x[7:4]));
    check({tag, "_early"}, 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_data"}, 32'(rsp_data), 32'(y));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; ovr = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_addr", 32'(lut_addr), 32'd0);

    single("x25", 8'h25, 8'd37);
    single("x7f", 8'h7F, 8'd112);
    single("xff", 8'hFF, 8'hFF);
    single("x80", 8'h80, 8'h80);
    ovr = 1'b1;
    single("ovr", 8'h3F, 8'h8F);
    step();
    ovr = 1'b0;

    // All four requesters streaming with the consumer always ready.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      req_data = $urandom;
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        check("rr_vld", 32'(rsp_valid), 32'd1);
        check("rr_id", 32'(rsp_id), 32'((k - 2) % 4));
      end
      step();
    end
    req_valid = '0;
    step(); step(); step();

    // Backpressure with two requests in flight.
    req_valid = 4'b0010; req_data = $urandom; rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_g1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0100; req_data = $urandom; rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_g2", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rdy0", 32'(req_ready), 32'd0);
      check("bp_vld", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_r1", 32'(rsp_id), 32'd1);
    step();
    @(negedge clk);
    check("bp_r2v", 32'(rsp_valid), 32'd1);
    check("bp_r2", 32'(rsp_id), 32'd2);
    step();
    @(negedge clk);
    check("bp_idle", 32'(rsp_valid), 32'd0);

    // Reset with two in flight, then requesters 0 and 3 compete.
    step();
    req_valid = 4'b0001; req_data = $urandom;
    step();
    req_valid = 4'b0010; req_data = $urandom;
    step();
    req_valid = '0; rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 4'b1001; req_data = $urandom;
    @(negedge clk);
    check("mr_vld0", 32'(rsp_valid), 32'd0);
    check("mr_g0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    check("mr_vld1", 32'(rsp_valid), 32'd0);
    check("mr_g3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
    check("mr_r0v", 32'(rsp_valid), 32'd1);
    check("mr_r0", 32'(rsp_id), 32'd0);
    step();
    @(negedge clk);
    check("mr_r3", 32'(rsp_id), 32'd3);
    step();

    // Random traffic with random consumer backpressure.
    for (int k = 0; k < 600; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    @(negedge clk);
    check("drain_q", 32'(q_id.size()), 32'd0);
    check("drain_vld", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/act_lut_arbiter.md
ACT_LUT_ARBITER -- requirements
Module: act_lut_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (LSTM gates i, f, g, o).
REQ-002 SHALL have parameter DW, default 8, signed data width.
REQ-003 SHALL have parameter AW, default 4, LUT address width; FW = DW-AW fraction bits.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ, per-requester request valid.
REQ-007 SHALL have port req_data, input, N_REQ*DW, signed x per requester; requester i in bits [i*DW +: DW].
REQ-008 SHALL have port req_ready, output, N_REQ, per-requester accept.
REQ-009 SHALL have port lut_addr, output, AW, address to the shared activation LUT.
REQ-010 SHALL have port lut_base, input, DW, signed LUT base value, combinational from lut_addr.
REQ-011 SHALL have port lut_next, input, DW, signed LUT next value, combinational from lut_addr.
REQ-012 SHALL have port rsp_valid, output, 1, response valid.
REQ-013 SHALL have port rsp_id, output, clog2(N_REQ), requester index of the response.
REQ-014 SHALL have port rsp_data, output, DW, signed activation result.
REQ-015 SHALL have port rsp_ready, input, 1, consumer accept.

Function
REQ-016 SHALL accept a request from requester i when req_valid[i] & req_ready[i] are both high in the same cycle.
REQ-017 SHALL assert at most one req_ready bit per cycle, and only for the granted valid requester; req_ready MAY depend combinationally on req_valid.
REQ-018 SHALL grant round-robin: search starts at (last accepted id + 1) mod N_REQ; pointer updates only on acceptance.
REQ-019 SHALL register an accepted request (x, id) into stage A; lut_addr = stage A x[DW-1:FW]; frac = x[FW-1:0] unsigned.
REQ-020 SHALL compute y = base + (((next - base) * frac) >>> FW): difference DW+1 bits signed, product DW+1+FW bits signed, arithmetic shift (floor).
REQ-021 SHALL truncate y to DW bits without saturation; y always lies between base and next inclusive.
REQ-022 SHALL register y and id into the output stage; latency: request accepted in cycle c gives rsp_valid in cycle c+2.
REQ-023 SHALL hold rsp_valid, rsp_id and rsp_data stable while rsp_valid & !rsp_ready.
REQ-024 SHALL advance the pipeline when !rsp_valid | rsp_ready; stage A loads when empty or advancing; otherwise all req_ready = 0.
REQ-025 SHALL sustain one accepted request and one response per cycle with rsp_ready held high.
REQ-026 SHALL drop rsp_valid after a handshake unless stage A holds valid data in the same cycle.
REQ-027 SHALL return responses in acceptance order and never drop or duplicate a request.
REQ-028 SHALL pass LUT wrap-around (address 15 → next = lut[0]) and top-segment clamp (address 7 → next = base) unmodified; these are LUT-side behaviour.

Reset
REQ-029 SHALL on rst: rsp_valid=0, rsp_id=0, rsp_data=0, stage A invalid with x=0 (lut_addr=0), RR pointer set so requester 0 has highest priority.
REQ-030 SHALL discard in-flight requests when rst is asserted mid-operation; req_ready=0 while rst is high.

Structure
REQ-031 SHALL place N_REQ, DW, AW, FW defaults and the id/data typedefs in shared package act_lut_pkg.
REQ-032 SHALL implement the interpolation of REQ-020/021 in combinational sub-module act_interp; the arbiter and pipeline live in the top level.

Verification (LUT stub: lut[a] = 16*signed(a); next per REQ-028)
REQ-033 SHALL cover: req 0 x=0x25 alone, rsp_ready=1 -> lut_addr=2 at c+1; rsp_valid at c+2, rsp_id=0, rsp_data=37.
REQ-034 SHALL cover: x=0x7F, 0xFF, 0x80 -> rsp_data 112, -1, -128.
REQ-035 SHALL cover: all four valid continuously, rsp_ready=1 -> ids 0,1,2,3,0,... one per cycle, no bubbles.
REQ-036 SHALL cover: rsp_ready=0 for 3 cycles with two requests in flight -> outputs stable, all req_ready=0 once stage A is full, both delivered in order after release.
REQ-037 SHALL cover: rst for 1 cycle with two in flight, then req 0 and req 3 valid -> rsp_valid=0 next cycle, first grant to 0, no stale response.
REQ-038 SHALL cover: stub base=127, next=-128, frac=15 -> rsp_data=-113.
